register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32 x 32-bit general register file (GR0-GR31) of the PA-RISC pipeline.
- Sits directly downstream of MEM_WB. Consumes its write-back triple (WB_PD_out, WB_RD_out, WB_RF_LE_out) as the write port.
- Supplies operands to the ID stage through three asynchronous read ports: A, B, and C. Port C carries store data and the third operand.
- GR0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and data port.
- NUM_REGS, 32, number of registers; address width is log2(NUM_REGS) = 5.

Ports:
- clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high; clears all registers.
- PW  input  32  write data, from MEM_WB WB_PD_out.
- RW  input  5  write address, from MEM_WB WB_RD_out.
- LE  input  1  write enable, from MEM_WB WB_RF_LE_out.
- RA  input  5  read address, port A.
- RB  input  5  read address, port B.
- RC  input  5  read address, port C.
- PA  output  32  read data, port A.
- PB  output  32  read data, port B.
- PC  output  32  read data, port C.

Behaviour:
- Storage: registers GR1-GR31 are flops. GR0 has no storage; reads of address 0 always return 32'h0.
- Reset: on any rising edge with Reset=1, GR1-GR31 become 0. A write presented in the same cycle is ignored because Reset has priority. Reset asserted mid-stream discards all prior contents. Read ports therefore return 0 for every address from the first edge after Reset.
- Write: on a rising edge with Reset=0 and LE=1, the register selected by RW takes PW.
  - Write latency is 1 edge; the new value is visible on reads after that edge.
  - LE=0 leaves all registers unchanged, regardless of PW and RW.
  - RW=0 with LE=1 is a legal no-op; GR0 stays 0.
- Read: PA, PB, PC are combinational functions of RA, RB, RC and the current register state; there is no read latency.
  - Ports are independent; any two or all three may address the same register.
  - Any read port may use the same address as RW.
- Same-cycle read/write of the same register (non-zero RW, LE=1): see Optional Feature.
- Write before Reset is ever asserted: contents are X until the first reset. The bench must reset first.
- No X propagation from an unaddressed register: each read mux selects exactly one register.
- Decoding: the 5-bit write address is decoded one-hot. At most one register is enabled per edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When LE=1, Reset=0, RW!=0, and a read address equals RW, that port returns PW combinationally in the same cycle (internal write-through forwarding).
  - This removes the WB-to-ID hazard.
  - Address 0 is never bypassed; it still reads 0.
  - With Reset=1, there is no bypass.
- Not defined:
  - Reads return the stored (old) value until the write edge; the new value appears after the edge.
  - The pipeline's forwarding unit must then cover WB-to-ID.

Test Plan:
- Reset then read all: Reset=1 for 1 edge, then sweep RA/RB/RC over 0-31 -> PA=PB=PC=32'h0 for every address.
- Write/read-back: write GR5=32'hDEADBEEF and GR31=32'h12345678 (LE=1), then read RA=5, RB=31, RC=5 -> PA=32'hDEADBEEF, PB=32'h12345678, PC=32'hDEADBEEF.
- GR0 immutability: LE=1, RW=0, PW=32'hFFFFFFFF for 1 edge, then RA=0 -> PA=32'h0. All other registers are unchanged.
- LE gating: LE=0, RW=7, PW=32'hAAAA5555 for 1 edge -> GR7 keeps its prior value (0 after reset).
- Same-cycle read/write: GR9 holds 32'h1. Present LE=1, RW=9, PW=32'h2, RA=9 before the edge:
  - With REGFILE_BYPASS_EN: PA=32'h2 before the edge.
  - Without it: PA=32'h1 before the edge and 32'h2 after it.
- Reset mid-operation: write GR3=32'hCAFEF00D, then assert Reset=1 with LE=1, RW=4, PW=32'h55 on the same edge -> after the edge, GR3=0 and GR4=0.

Source files
------------

// File: rtl/register_file.sv
// 32 x 32 general register file: one synchronous write port, three combinational read ports, GR0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] PW,
  input  logic [AW-1:0]     RW,
  input  logic              LE,
  input  logic [AW-1:0]     RA,
  input  logic [AW-1:0]     RB,
  input  logic [AW-1:0]     RC,
  output logic [DATA_W-1:0] PA,
  output logic [DATA_W-1:0] PB,
  output logic [DATA_W-1:0] PC
);

  logic [DATA_W-1:0]   regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] wr_sel;

  // One-hot write decode; bit 0 is forced low so GR0 never has an enable.
  always_comb begin
    wr_sel = '0;
    if (LE) wr_sel[RW] = 1'b1;
    wr_sel[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (Reset)          regs[i] <= '0;
      else if (wr_sel[i]) regs[i] <= PW;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [AW-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (addr != '0) begin
`ifdef REGFILE_BYPASS_EN
      if (!Reset && LE && (addr == RW)) val = PW;
      else                              val = regs[addr];
`else
      val = regs[addr];
`endif
    end
    return val;
  endfunction

  always_comb PA = rd_port(RA);
  always_comb PB = rd_port(RB);
  always_comb PC = rd_port(RC);

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed literal checks plus randomized traffic against an array model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] PW;
  logic [4:0]  RW;
  logic        LE;
  logic [4:0]  RA, RB, RC;
  logic [31:0] PA, PB, PC;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [31:0] model [32];

  register_file #(.DATA_W(32), .NUM_REGS(32)) dut (
    .clk(clk), .Reset(Reset), .PW(PW), .RW(RW), .LE(LE),
    .RA(RA), .RB(RB), .RC(RC), .PA(PA), .PB(PB), .PC(PC)
  );

  always #5 clk = ~clk;

  // Architectural state: what each GR must hold after every edge.
  always @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (LE && RW != 5'd0) begin
      model[RW] = PW;
    end
  end

  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (!Reset && LE && a == RW) return PW;
`endif
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_PA", PA, expect_rd(RA));
      check("model_PB", PB, expect_rd(RB));
      check("model_PC", PC, expect_rd(RC));
    end
  end

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    RW = a; PW = d; LE = 1'b1;
    @(posedge clk); #1;
    LE = 1'b0;
  endtask

  initial begin
    model[0] = 32'h0;
    Reset = 1'b1; LE = 1'b0; RW = '0; PW = '0; RA = '0; RB = '0; RC = '0;
    @(posedge clk); #1;
    Reset = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(31 - i); RC = 5'(i);
      #1;
      check("reset_PA", PA, 32'h0);
      check("reset_PB", PB, 32'h0);
      check("reset_PC", PC, 32'h0);
    end

    do_write(5'd5, 32'hDEADBEEF);
    do_write(5'd31, 32'h12345678);
    RA = 5'd5; RB = 5'd31; RC = 5'd5; #1;
    check("wr_PA", PA, 32'hDEADBEEF);
    check("wr_PB", PB, 32'h12345678);
    check("wr_PC", PC, 32'hDEADBEEF);

    do_write(5'd0, 32'hFFFFFFFF);
    RA = 5'd0; RB = 5'd5; RC = 5'd31; #1;
    check("gr0_PA", PA, 32'h0);
    check("gr0_keep5", PB, 32'hDEADBEEF);
    check("gr0_keep31", PC, 32'h12345678);

    LE = 1'b0; RW = 5'd7; PW = 32'hAAAA5555;
    @(posedge clk); #1;
    RA = 5'd7; #1;
    check("le_gate", PA, 32'h0);

    do_write(5'd9, 32'h1);
    RW = 5'd9; PW = 32'h2; LE = 1'b1; RA = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cyc_pre", PA, 32'h2);
`else
    check("same_cyc_pre", PA, 32'h1);
`endif
    @(posedge clk); #1;
    LE = 1'b0; #1;
    check("same_cyc_post", PA, 32'h2);

    do_write(5'd3, 32'hCAFEF00D);
    Reset = 1'b1; LE = 1'b1; RW = 5'd4; PW = 32'h55; RA = 5'd3; RB = 5'd4; #1;
    check("rst_pre_GR3", PA, 32'hCAFEF00D);
    @(posedge clk); #1;
    Reset = 1'b0; LE = 1'b0; #1;
    check("rst_GR3", PA, 32'h0);
    check("rst_GR4", PB, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      RW = 5'($urandom_range(0, 31));
      PW = $urandom;
      LE = ($urandom_range(0, 3) != 0);
      Reset = ($urandom_range(0, 99) == 0);
      RA = ($urandom_range(0, 3) == 0) ? RW : 5'($urandom_range(0, 31));
      RB = ($urandom_range(0, 3) == 0) ? RW : 5'($urandom_range(0, 31));
      RC = ($urandom_range(0, 7) == 0) ? RA : 5'($urandom_range(0, 31));
      @(posedge clk); #1;
    end

    Reset = 1'b0; LE = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
